// File: rtl/keyboard_scancode_translator.sv
`default_nettype none
// ============================================================================
// keyboard_scancode_translator
//   Set-1 prefix FSM with runtime-loadable normal/E0 tables and a FWFT FIFO.
//   Rev 1.0
// ============================================================================
module keyboard_scancode_translator #(
   parameter int FIFO_DEPTH     = 8,
   parameter bit MODE_DEFAULT   = 1'b1,
   parameter bit DROP_FAKE_SHFT = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    in_data_i,
   input  logic                          in_valid_i,
   input  logic                          mode_wr_i,
   input  logic                          mode_i,
   input  logic                          tbl_we_i,
   input  logic                          tbl_sel_i,
   input  logic [6:0]                    tbl_addr_i,
   input  logic [7:0]                    tbl_wdata_i,
   output logic [7:0]                    out_data_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   input  logic                          ovf_clear_i
);

   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_E0_SEEN = 2'd1,
      ST_E1_A    = 2'd2,
      ST_E1_B    = 2'd3
   } state_t;

   function automatic logic [7:0] norm_default(input logic [6:0] idx);
      case (idx)
         7'h4A:   norm_default = 8'h53;
         7'h4E:   norm_default = 8'h55;
         7'h53:   norm_default = 8'h56;
         7'h57:   norm_default = 8'h59;
         7'h58:   norm_default = 8'h5A;
         default: norm_default = {1'b0, idx};
      endcase
   endfunction

   function automatic logic [7:0] e0_default(input logic [6:0] idx);
      case (idx)
         7'h48:   e0_default = 8'h29;
         7'h4B:   e0_default = 8'h2B;
         7'h50:   e0_default = 8'h4A;
         7'h4D:   e0_default = 8'h4E;
         7'h1C:   e0_default = 8'h57;
         7'h47:   e0_default = 8'h58;
         default: e0_default = {1'b0, idx};
      endcase
   endfunction

   state_t          state_q, state_d;
   logic            mode_q;
   logic [7:0]      norm_q [128];
   logic [7:0]      e0_q   [128];
   logic            push_q, push_d;
   logic [7:0]      push_data_q, push_data_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            overflow_q;

   logic            fake_shift;
   logic [7:0]      lk_entry;
   logic            do_push, do_pop, fifo_full;

   assign fake_shift = (in_data_i[6:0] == 7'h2A) || (in_data_i[6:0] == 7'h36);

   always_comb begin
      state_d     = state_q;
      push_d      = 1'b0;
      push_data_d = 8'h00;
      lk_entry    = 8'h00;
      if (in_valid_i) begin
         if (!mode_q) begin
            push_d      = 1'b1;
            push_data_d = in_data_i;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (in_data_i == 8'hE0)      state_d = ST_E0_SEEN;
                  else if (in_data_i == 8'hE1) state_d = ST_E1_A;
                  else                         lk_entry = norm_q[in_data_i[6:0]];
               end
               ST_E0_SEEN: begin
                  state_d = ST_IDLE;
                  if (!(DROP_FAKE_SHFT && fake_shift)) lk_entry = e0_q[in_data_i[6:0]];
               end
               ST_E1_A: state_d = ST_E1_B;
               default: state_d = ST_IDLE;
            endcase
            // A zero entry means the key is suppressed; the break bit rides through.
            if (lk_entry != 8'h00) begin
               push_d      = 1'b1;
               push_data_d = {in_data_i[7], lk_entry[6:0]};
            end
         end
      end
      if (mode_wr_i || !mode_q) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_DEFAULT;
         push_q      <= 1'b0;
         push_data_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         if (mode_wr_i) mode_q <= mode_i;
      end
   end

   for (genvar i = 0; i < 128; i++) begin : g_tbl
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            norm_q[i] <= norm_default(7'(i));
            e0_q[i]   <= e0_default(7'(i));
         end else if (tbl_we_i && (tbl_addr_i == 7'(i))) begin
            if (tbl_sel_i) e0_q[i]   <= tbl_wdata_i;
            else           norm_q[i] <= tbl_wdata_i;
         end
      end
   end

   // Depth is a power of two, so the count MSB alone marks a full FIFO.
   assign fifo_full = count_q[AW];
   assign do_pop    = (count_q != '0) && out_ready_i;
   assign do_push   = push_q && (!fifo_full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) fifo_q[wr_ptr_q] <= push_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
         else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
         if (push_q && !do_push) overflow_q <= 1'b1;
         else if (ovf_clear_i)   overflow_q <= 1'b0;
      end
   end

   assign out_valid_o  = (count_q != '0);
   assign out_data_o   = out_valid_o ? fifo_q[rd_ptr_q] : 8'h00;
   assign fifo_level_o = count_q;
   assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_scancode_translator.sv
`default_nettype none
// ============================================================================
// tb_keyboard_scancode_translator
//   Scenario tasks against a queue-based scancode model. Rev 1.0
// ============================================================================
module tb_keyboard_scancode_translator;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       mode_wr = 1'b0;
   logic       mode_in = 1'b0;
   logic       tbl_we = 1'b0;
   logic       tbl_sel = 1'b0;
   logic [6:0] tbl_addr = 7'h00;
   logic [7:0] tbl_wdata = 8'h00;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [$clog2(DEPTH):0] fifo_level;
   logic       overflow;
   logic       ovf_clear = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int max_level = 0;

   logic [7:0] m_norm [128];
   logic [7:0] m_e0   [128];
   bit m_mode;
   bit m_e0_pending;
   int m_e1_left;

   keyboard_scancode_translator #(.FIFO_DEPTH(DEPTH), .MODE_DEFAULT(1'b1), .DROP_FAKE_SHFT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data_i(in_data), .in_valid_i(in_valid),
      .mode_wr_i(mode_wr), .mode_i(mode_in),
      .tbl_we_i(tbl_we), .tbl_sel_i(tbl_sel), .tbl_addr_i(tbl_addr), .tbl_wdata_i(tbl_wdata),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .fifo_level_o(fifo_level), .overflow_o(overflow), .ovf_clear_i(ovf_clear)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) begin
         m_norm[i] = 8'(i);
         m_e0[i]   = 8'(i);
      end
      m_norm['h4A] = 8'h53; m_norm['h4E] = 8'h55; m_norm['h53] = 8'h56;
      m_norm['h57] = 8'h59; m_norm['h58] = 8'h5A;
      m_e0['h48] = 8'h29; m_e0['h4B] = 8'h2B; m_e0['h50] = 8'h4A;
      m_e0['h4D] = 8'h4E; m_e0['h1C] = 8'h57; m_e0['h47] = 8'h58;
      m_mode = 1'b1;
      m_e0_pending = 1'b0;
      m_e1_left = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [7:0] e;
      if (!m_mode) begin
         exp_q.push_back(b);
         return;
      end
      if (m_e1_left > 0) begin
         m_e1_left--;
         return;
      end
      if (m_e0_pending) begin
         m_e0_pending = 1'b0;
         if (b[6:0] == 7'h2A || b[6:0] == 7'h36) return;
         e = m_e0[b[6:0]];
      end else if (b == 8'hE0) begin
         m_e0_pending = 1'b1;
         return;
      end else if (b == 8'hE1) begin
         m_e1_left = 2;
         return;
      end else begin
         e = m_norm[b[6:0]];
      end
      if (e != 8'h00) exp_q.push_back({b[7], e[6:0]});
   endfunction

   function automatic void model_mode(input bit m);
      m_mode = m;
      m_e0_pending = 1'b0;
      m_e1_left = 0;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      in_data = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic write_tbl(input bit sel, input logic [6:0] addr, input logic [7:0] data);
      tbl_sel = sel; tbl_addr = addr; tbl_wdata = data; tbl_we = 1'b1;
      if (sel) m_e0[addr] = data; else m_norm[addr] = data;
      @(posedge clk); #1;
      tbl_we = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!out_valid) break;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid) begin
         errors++;
         $display("FAIL drain_timeout out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
      checks++; if (fifo_level !== '0)   begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_basic_latency();
      logic [7:0] ins [4];
      logic [7:0] want [4];
      ins  = '{8'h1E, 8'h4A, 8'h57, 8'hCA};
      want = '{8'h1E, 8'h53, 8'h59, 8'hD3};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model_byte(ins[i]);
         send_byte(ins[i]);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early[%0d] out_valid=%b want 0", i, out_valid); end
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] out_valid=%b want 1", i, out_valid); end
         checks++;
         if (out_data !== want[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data, want[i]); end
         @(posedge clk); #1;
      end
      drain();
      got.delete(); exp_q.delete();
   endtask

   task automatic test_e0();
      logic [7:0] seq [6];
      seq = '{8'hE0, 8'h48, 8'hE0, 8'h1C, 8'hE0, 8'hAA};
      got.delete(); exp_q.delete();
      out_ready = 1'b1;
      foreach (seq[i]) begin
         model_byte(seq[i]);
         send_byte(seq[i]);
      end
      drain();
      checks++;
      if (got.size() != 2) begin errors++; $display("FAIL e0_count got %0d want 2", got.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL e0_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_e1();
      logic [7:0] seq [4];
      seq = '{8'hE1, 8'h1D, 8'h45, 8'h1E};
      got.delete(); exp_q.delete();
      out_ready = 1'b1;
      max_level = 0;
      foreach (seq[i]) begin
         model_byte(seq[i]);
         send_byte(seq[i]);
      end
      drain();
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("FAIL e1_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL e1_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
      checks++;
      if (max_level != 1) begin errors++; $display("FAIL e1_max_level got %0d want 1", max_level); end
   endtask

   task automatic test_table_write();
      got.delete(); exp_q.delete();
      out_ready = 1'b1;
      write_tbl(1'b0, 7'h1E, 8'h20);
      write_tbl(1'b1, 7'h48, 8'h00);
      model_byte(8'h1E); send_byte(8'h1E);
      model_byte(8'hE0); send_byte(8'hE0);
      model_byte(8'h48); send_byte(8'h48);
      // lookup and write of the same entry on one edge
      in_data = 8'h1E; in_valid = 1'b1;
      tbl_sel = 1'b0; tbl_addr = 7'h1E; tbl_wdata = 8'h30; tbl_we = 1'b1;
      model_byte(8'h1E);
      m_norm['h1E] = 8'h30;
      @(posedge clk); #1;
      in_valid = 1'b0; tbl_we = 1'b0;
      model_byte(8'h1E); send_byte(8'h1E);
      drain();
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("FAIL tbl_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL tbl_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_overflow();
      got.delete(); exp_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) send_byte(8'(8'h10 + i));
      for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (fifo_level !== DEPTH) begin errors++; $display("FAIL ovf_level got %0d want %0d", fifo_level, DEPTH); end
      checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      checks++; if (out_data !== 8'h10)   begin errors++; $display("FAIL ovf_head got %h want 10", out_data); end
      @(posedge clk); #1;
      send_byte(8'h20);
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
      @(posedge clk); #1;
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      @(negedge clk);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
      @(posedge clk); #1;
      send_byte(8'h21);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++; if (fifo_level !== DEPTH) begin errors++; $display("FAIL full_pushpop_level got %0d want %0d", fifo_level, DEPTH); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL full_pushpop_ovf got %b want 0", overflow); end
      @(posedge clk); #1;
      exp_q.push_back(8'h21);
      drain();
      checks++;
      if (got.size() != DEPTH + 1) begin errors++; $display("FAIL ovf_count got %0d want %0d", got.size(), DEPTH + 1); end
      for (int i = 0; i < got.size(); i++) begin
         logic [7:0] w;
         w = (i == 0) ? 8'h10 : ((i - 1 < exp_q.size()) ? exp_q[i - 1] : 8'hXX);
         checks++;
         if (got[i] !== w) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, got[i], w); end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int r;
      got.delete(); exp_q.delete();
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid = 1'b0; tbl_we = 1'b0; mode_wr = 1'b0;
         out_ready = (cyc % 4 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         if (cyc % 4 == 0 && $urandom_range(0, 2) != 0) begin
            r = $urandom_range(0, 7);
            case (r)
               0: b = 8'hE0;
               1: b = 8'hE1;
               2: b = ($urandom_range(0, 1) != 0) ? 8'h2A : 8'hB6;
               default: b = 8'($urandom);
            endcase
            in_data = b; in_valid = 1'b1;
            model_byte(b);
         end
         if ($urandom_range(0, 15) == 0) begin
            tbl_sel = 1'($urandom); tbl_addr = 7'($urandom);
            tbl_wdata = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tbl_we = 1'b1;
            if (tbl_sel) m_e0[tbl_addr] = tbl_wdata; else m_norm[tbl_addr] = tbl_wdata;
         end
         if (cyc % 4 == 2 && $urandom_range(0, 31) == 0) begin
            mode_in = 1'($urandom); mode_wr = 1'b1;
            model_mode(mode_in);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; tbl_we = 1'b0; mode_wr = 1'b0;
      drain();
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_mode_and_reset();
      got.delete(); exp_q.delete();
      out_ready = 1'b1;
      mode_in = 1'b1; mode_wr = 1'b1; model_mode(1'b1);
      @(posedge clk); #1;
      mode_wr = 1'b0;
      model_byte(8'hE0); send_byte(8'hE0);
      mode_in = 1'b0; mode_wr = 1'b1; model_mode(1'b0);
      @(posedge clk); #1;
      mode_wr = 1'b0;
      model_byte(8'hE0); send_byte(8'hE0);
      model_byte(8'h48); send_byte(8'h48);
      drain();
      checks++;
      if (got.size() != 2) begin errors++; $display("FAIL pass_count got %0d want 2", got.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL pass_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
      out_ready = 1'b0;
      send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
      checks++; if (fifo_level !== '0)  begin errors++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      got.delete(); exp_q.delete();
      out_ready = 1'b1;
      model_byte(8'h1E); send_byte(8'h1E);
      model_byte(8'hE0); send_byte(8'hE0);
      model_byte(8'h48); send_byte(8'h48);
      model_byte(8'h4A); send_byte(8'h4A);
      drain();
      checks++;
      if (got.size() != 3) begin errors++; $display("FAIL postrst_count got %0d want 3", got.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin errors++; $display("FAIL postrst_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_e0();
      test_e1();
      test_table_write();
      test_overflow();
      test_random();
      test_mode_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
